// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM bus controller slice.
package ram_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;
    localparam int NUM_REQ    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        SAMPLE  = 2'd2,
        RELEASE = 2'd3
    } ram_ctrl_state_t;

    // One-hot completion vector for a requester id.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: combinational grant, registered last_grant for round-robin fairness.
module rr_arb2
    import ram_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic               grant_id,
    output logic               grant_valid
);

    logic last_grant_r;
    logic grant_id_s;

    // Pick the winner; a tie goes to the requester not served last (or to 0 when fixed).
    always_comb begin
        grant_id_s = 1'b0;
        if (req == 2'b11) begin
            if (FIXED_PRIO != 0) begin
                grant_id_s = 1'b0;
            end else begin
                grant_id_s = ~last_grant_r;
            end
        end else if (req[1]) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Remember who was granted last.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (take && (req != 2'b00)) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign grant_id    = grant_id_s;
    assign grant_valid = (req != 2'b00);

endmodule

// File: rtl/ram_bus_ctrl.sv
// Sequences the shared RAM for two requesters: arbitration, wm/wb strobes, addr and the tri-state data bus.
module ram_bus_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_wm,
    output logic                      ram_wb,
    inout  wire  [DATA_W-1:0]         ram_data
);

    ram_ctrl_state_t     state_r;
    logic                id_r;
    logic                we_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                drive_r;
    logic [NUM_REQ-1:0]  ack_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                busy_r;
    logic [ADDR_W-1:0]   ram_addr_r;
    logic                ram_wm_r;
    logic                ram_wb_r;

    logic                grant_id_s;
    logic                grant_valid_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .take        (state_r == IDLE),
        .grant_id    (grant_id_s),
        .grant_valid (grant_valid_s)
    );

    // Route the winner's request fields; only these get latched.
    always_comb begin
        if (grant_id_s) begin
            sel_we_s    = req_we[1];
            sel_addr_s  = req_addr[2*ADDR_W-1:ADDR_W];
            sel_wdata_s = req_wdata[2*DATA_W-1:DATA_W];
        end else begin
            sel_we_s    = req_we[0];
            sel_addr_s  = req_addr[ADDR_W-1:0];
            sel_wdata_s = req_wdata[DATA_W-1:0];
        end
    end

    // Controller FSM; every output is registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            id_r       <= 1'b0;
            we_r       <= 1'b0;
            wdata_r    <= {DATA_W{1'b0}};
            drive_r    <= 1'b0;
            ack_r      <= 2'b00;
            rd_data_r  <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            ram_addr_r <= {ADDR_W{1'b0}};
            ram_wm_r   <= 1'b0;
            ram_wb_r   <= 1'b0;
        end else begin
            ack_r <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_r    <= ACCESS;
                        id_r       <= grant_id_s;
                        we_r       <= sel_we_s;
                        wdata_r    <= sel_wdata_s;
                        ram_addr_r <= sel_addr_s;
                        busy_r     <= 1'b1;
                        ram_wm_r   <= sel_we_s;
                        ram_wb_r   <= ~sel_we_s;
                        drive_r    <= sel_we_s;
                    end else begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        ram_wm_r <= 1'b0;
                        ram_wb_r <= 1'b0;
                        drive_r  <= 1'b0;
                    end
                end
                ACCESS: begin
                    busy_r  <= 1'b1;
                    drive_r <= 1'b0;
                    if (we_r) begin
                        state_r  <= RELEASE;
                        ram_wm_r <= 1'b0;
                        ram_wb_r <= 1'b0;
                        ack_r    <= req_onehot(id_r);
                    end else begin
                        state_r  <= SAMPLE;
                        ram_wm_r <= 1'b0;
                        ram_wb_r <= 1'b1;
                    end
                end
                SAMPLE: begin
                    // wm+wb together makes the RAM latch Z into its bus driver without writing.
                    state_r   <= RELEASE;
                    rd_data_r <= ram_data;
                    busy_r    <= 1'b1;
                    drive_r   <= 1'b0;
                    ram_wm_r  <= 1'b1;
                    ram_wb_r  <= 1'b1;
                    ack_r     <= req_onehot(id_r);
                end
                RELEASE: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    drive_r  <= 1'b0;
                    ram_wm_r <= 1'b0;
                    ram_wb_r <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    drive_r  <= 1'b0;
                    ram_wm_r <= 1'b0;
                    ram_wb_r <= 1'b0;
                end
            endcase
        end
    end

    assign ram_data = drive_r ? wdata_r : {DATA_W{1'bz}};
    assign ack      = ack_r;
    assign rd_data  = rd_data_r;
    assign busy     = busy_r;
    assign ram_addr = ram_addr_r;
    assign ram_wm   = ram_wm_r;
    assign ram_wb   = ram_wb_r;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Directed bench for ram_bus_ctrl with a registered-driver RAM model; a second instance covers FIXED_PRIO=1.
module tb_ram_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    wire  [1:0]  ack;
    wire  [7:0]  rd_data;
    wire         busy;
    wire  [7:0]  ram_addr;
    wire         ram_wm;
    wire         ram_wb;
    wire  [7:0]  ram_data;

    wire  [1:0]  fp_ack;
    wire  [7:0]  fp_rd_data;
    wire         fp_busy;
    wire  [7:0]  fp_ram_addr;
    wire         fp_ram_wm;
    wire         fp_ram_wb;
    wire  [7:0]  fp_data;

    int checks   = 0;
    int failures = 0;
    int conflicts = 0;
    int dbl_ack   = 0;

    always #5 clk = ~clk;

    ram_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rd_data(rd_data), .busy(busy),
        .ram_addr(ram_addr), .ram_wm(ram_wm), .ram_wb(ram_wb), .ram_data(ram_data)
    );

    ram_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(fp_ack), .rd_data(fp_rd_data), .busy(fp_busy),
        .ram_addr(fp_ram_addr), .ram_wm(fp_ram_wm), .ram_wb(fp_ram_wb), .ram_data(fp_data)
    );

    // RAM model: registered bus driver, turned off by wm+wb together.
    logic [7:0] mem [0:255];
    logic       mem_drv;
    logic [7:0] mem_q;

    always @(posedge clk) begin
        if (rst) begin
            mem_drv <= 1'b0;
        end else if (ram_wm && ram_wb) begin
            mem_drv <= 1'b0;
        end else if (ram_wb) begin
            mem_drv <= 1'b1;
            mem_q   <= mem[ram_addr];
        end else if (ram_wm) begin
            mem[ram_addr] <= ram_data;
        end
    end

    assign ram_data = mem_drv ? mem_q : 8'hzz;

    // Bus contention and ack exclusivity monitor.
    always @(negedge clk) begin
        if (ram_wm && !ram_wb && mem_drv) conflicts <= conflicts + 1;
        if (ack == 2'b11) dbl_ack <= dbl_ack + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, input logic [1:0] mask, output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if ((ack & mask) != 2'b00) break;
        end
        chk(tag, ((ack & mask) != 2'b00), 1'b1);
    endtask

    task automatic txn(input string tag, input int id, input logic we,
                       input logic [7:0] a, input logic [7:0] d, output int cyc);
        req_we[id]          = we;
        req_addr[id*8 +: 8] = a;
        req_wdata[id*8 +: 8] = d;
        req[id]             = 1'b1;
        wait_ack(tag, (id != 0) ? 2'b10 : 2'b01, cyc);
        req[id] = 1'b0;
        step();
    endtask

    int         cyc;
    int         n_rr;
    int         fp_n0;
    int         fp_n1;
    logic [7:0] rr_ids;

    initial begin
        rst = 1'b1; req = 2'b00; req_we = 2'b00; req_addr = 16'h0000; req_wdata = 16'h0000;
        repeat (3) step();
        chk("rst_ack", ack, 2'b00);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_strobes", {ram_wm, ram_wb}, 2'b00);
        chk("rst_addr", ram_addr, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bus_z", (ram_data === 8'hzz), 1'b1);
        rst = 1'b0;
        step();

        // 1: req0 write 0x10 = 0xA5
        req_we[0] = 1'b1; req_addr[7:0] = 8'h10; req_wdata[7:0] = 8'hA5; req[0] = 1'b1;
        step();
        chk("t1_strobes_T1", {ram_wm, ram_wb}, 2'b10);
        chk("t1_bus_T1", ram_data, 8'hA5);
        chk("t1_addr_T1", ram_addr, 8'h10);
        chk("t1_busy_T1", busy, 1'b1);
        step();
        chk("t1_ack_T2", ack, 2'b01);
        req[0] = 1'b0;
        step();
        chk("t1_ack_T3", ack, 2'b00);
        chk("t1_mem", mem[8'h10], 8'hA5);

        // 2: req1 read 0x10
        req_we[1] = 1'b0; req_addr[15:8] = 8'h10; req[1] = 1'b1;
        step();
        chk("t2_strobes_T1", {ram_wm, ram_wb}, 2'b01);
        step();
        chk("t2_strobes_T2", {ram_wm, ram_wb}, 2'b01);
        step();
        chk("t2_strobes_T3", {ram_wm, ram_wb}, 2'b11);
        chk("t2_ack_T3", ack, 2'b10);
        chk("t2_rd_data_T3", rd_data, 8'hA5);
        req[1] = 1'b0;
        step();
        chk("t2_bus_z_T4", (ram_data === 8'hzz), 1'b1);
        chk("t2_ack_T4", ack, 2'b00);

        // 6: address extremes
        txn("t6_wr_ff_ack", 0, 1'b1, 8'hFF, 8'h01, cyc);
        chk("t6_wr_latency", cyc, 2);
        txn("t6_rd_ff_ack", 1, 1'b0, 8'hFF, 8'h00, cyc);
        chk("t6_rd_latency", cyc, 3);
        chk("t6_rd_ff", rd_data, 8'h01);
        txn("t6_wr_00_ack", 0, 1'b1, 8'h00, 8'h7E, cyc);
        txn("t6_rd_00_ack", 1, 1'b0, 8'h00, 8'h00, cyc);
        chk("t6_rd_00", rd_data, 8'h7E);
        chk("t6_mem_ff", mem[8'hFF], 8'h01);

        // 4: read then immediate write from req0, req held across the ack
        req_we[0] = 1'b0; req_addr[7:0] = 8'h00; req[0] = 1'b1;
        wait_ack("t4_rd_ack", 2'b01, cyc);
        chk("t4_rd_data", rd_data, 8'h7E);
        req_we[0] = 1'b1; req_addr[7:0] = 8'h30; req_wdata[7:0] = 8'h99;
        wait_ack("t4_wr_ack", 2'b01, cyc);
        chk("t4_wr_latency", cyc, 3);
        req[0] = 1'b0;
        step();
        chk("t4_mem", mem[8'h30], 8'h99);
        chk("t4_conflicts", conflicts, 0);

        // 5: reset during SAMPLE, request held
        req_we[1] = 1'b0; req_addr[15:8] = 8'h10; req[1] = 1'b1;
        step();
        step();
        chk("t5_in_sample", {ram_wm, ram_wb}, 2'b01);
        rst = 1'b1;
        step();
        chk("t5_busy", busy, 1'b0);
        chk("t5_strobes", {ram_wm, ram_wb}, 2'b00);
        chk("t5_ack", ack, 2'b00);
        chk("t5_bus_z", (ram_data === 8'hzz), 1'b1);
        chk("t5_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        wait_ack("t5_serve_ack", 2'b10, cyc);
        chk("t5_serve_latency", cyc, 3);
        chk("t5_serve_data", rd_data, 8'hA5);
        req[1] = 1'b0;
        step();

        // 3: both held from reset; round-robin alternates, fixed priority starves req1
        rst = 1'b1;
        step();
        req_we = 2'b10; req_addr = 16'h2010; req_wdata = 16'h3C00; req = 2'b11; rst = 1'b0;
        n_rr = 0; fp_n0 = 0; fp_n1 = 0; rr_ids = 8'h00;
        for (int i = 0; i < 18; i++) begin
            step();
            if (ack != 2'b00) begin
                if (n_rr < 8) rr_ids[n_rr] = ack[1];
                n_rr++;
            end
            if (fp_ack[0]) fp_n0++;
            if (fp_ack[1]) fp_n1++;
        end
        req = 2'b00;
        step();
        chk("t3_rr_count", n_rr, 5);
        chk("t3_rr_order", rr_ids[4:0], 5'b01010);
        chk("t3_mem_20", mem[8'h20], 8'h3C);
        chk("t3_fp_req0", fp_n0, 4);
        chk("t3_fp_req1", fp_n1, 0);

        chk("ack_onehot", dbl_ack, 0);
        chk("bus_conflicts", conflicts, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
